voice_mix_scheduler: RTL and testbench

- Sequences sample production for the I2S DAC transmitter.
- On each per-channel frame strobe from the transmitter, polls NUM_VOICES voice generators round-robin with a req/ack handshake and accumulates their samples.
- Saturates the sum to SAMPLE_W and hands it to the transmitter over valid/ready.
- Sits between the synth voice bank and the I2S serializer; the only arbiter of voice access to the DAC path.

---
 rtl/synth_pkg.sv | 34 +++
 rtl/voice_mix_scheduler_if.sv | 32 +++
 rtl/mix_saturate.sv | 24 ++
 rtl/voice_mix_scheduler.sv | 179 +++++++++++++++++
 tb/tb_voice_mix_scheduler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared synth-path types: scheduler state, default sample format, channel ids and the
// default-width saturation helper used by the mixing and effects paths.
package synth_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned ACC_W      = SAMPLE_W + $clog2(NUM_VOICES) + 1;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StOut
  } state_e;

  // Value fits when every bit above the sample's sign bit repeats the accumulator sign.
  function automatic sample_t sat_to_sample(input acc_t acc);
    sample_t res;
    if (acc[ACC_W-1:SAMPLE_W-1] == {(ACC_W-SAMPLE_W+1){acc[ACC_W-1]}}) begin
      res = acc[SAMPLE_W-1:0];
    end else if (acc[ACC_W-1]) begin
      res = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      res = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/voice_mix_scheduler_if.sv
// Frame request, voice polling bus and mixed-sample stream of the voice mix scheduler.
// master = scheduler side, slave = transmitter + voice bank side.
interface voice_mix_scheduler_if #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned SAMPLE_W   = 16
);

  logic                           frame_strobe;
  logic                           frame_ch;
  logic [NUM_VOICES-1:0]          mute_mask;
  logic [NUM_VOICES-1:0]          voice_req;
  logic                           voice_ch;
  logic [NUM_VOICES-1:0]          voice_ack;
  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data;
  logic                           out_valid;
  logic signed [SAMPLE_W-1:0]     out_data;
  logic                           out_ch;
  logic                           out_ready;
  logic                           overrun;
  logic                           timeout;

  modport master (
    input  frame_strobe, frame_ch, mute_mask, voice_ack, voice_data, out_ready,
    output voice_req, voice_ch, out_valid, out_data, out_ch, overrun, timeout
  );

  modport slave (
    output frame_strobe, frame_ch, mute_mask, voice_ack, voice_data, out_ready,
    input  voice_req, voice_ch, out_valid, out_data, out_ch, overrun, timeout
  );

endinterface

// File: rtl/mix_saturate.sv
// Combinational clamp of a wide signed mix accumulator to a signed sample width.
module mix_saturate #(
  parameter int unsigned IN_W  = 19,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] sample
);

  logic fits;

  assign fits = (acc[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){acc[IN_W-1]}});

  always_comb begin
    if (fits) begin
      sample = acc[OUT_W-1:0];
    end else if (acc[IN_W-1]) begin
      sample = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sample = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/voice_mix_scheduler.sv
// Per-frame round-robin voice poller and saturating mixer feeding the I2S transmitter.
// Optional per-voice ack timeout is enabled with `define VOICE_TIMEOUT_EN.
module voice_mix_scheduler #(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic                   clk,
  input logic                   rst,
  voice_mix_scheduler_if.master bus
);

  import synth_pkg::*;

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned MIX_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;

  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic signed [MIX_W-1:0] mix_t;

  state_e                     state_q, state_d;
  idx_t                       idx_q, idx_d;
  mix_t                       acc_q, acc_d;
  logic [NUM_VOICES-1:0]      mask_q, mask_d;
  logic                       ch_q, ch_d;
  logic signed [SAMPLE_W-1:0] out_data_q, sat_out;
  logic                       overrun_q, overrun_d;
  logic                       timeout_q, timeout_d;
  logic                       advance;
  logic                       load_out;

  idx_t first_idx, next_idx;
  logic first_ok, next_ok;
  mix_t voice_ext [NUM_VOICES];

`ifdef VOICE_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_ext
    assign voice_ext[g] = {{(MIX_W-SAMPLE_W){bus.voice_data[g*SAMPLE_W+SAMPLE_W-1]}},
                           bus.voice_data[g*SAMPLE_W +: SAMPLE_W]};
  end

  // Lowest unmuted voice of a new frame, and the next unmuted voice after the current one.
  always_comb begin
    first_ok  = 1'b0;
    first_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!bus.mute_mask[i]) begin
        first_ok  = 1'b1;
        first_idx = idx_t'(i);
      end
    end
    next_ok  = 1'b0;
    next_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!mask_q[i] && (i > int'(idx_q))) begin
        next_ok  = 1'b1;
        next_idx = idx_t'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    mask_d    = mask_q;
    ch_d      = ch_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;
    advance   = 1'b0;
`ifdef VOICE_TIMEOUT_EN
    wait_d    = wait_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.frame_strobe) begin
          ch_d    = bus.frame_ch;
          mask_d  = bus.mute_mask;
          acc_d   = '0;
          idx_d   = first_idx;
          state_d = first_ok ? StReq : StOut;
`ifdef VOICE_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      StReq: begin
        if (bus.voice_ack[idx_q]) begin
          acc_d   = acc_q + voice_ext[idx_q];
          advance = 1'b1;
`ifdef VOICE_TIMEOUT_EN
        end else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          // Silent voice: contributes nothing, frame keeps moving.
          advance   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
`endif
        end
        if (advance) begin
`ifdef VOICE_TIMEOUT_EN
          wait_d = '0;
`endif
          if (next_ok) begin
            idx_d = next_idx;
          end else begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if ((state_q != StIdle) && bus.frame_strobe) begin
      overrun_d = 1'b1;
    end
  end

  assign load_out = (state_q != StOut) && (state_d == StOut);

  mix_saturate #(
    .IN_W  (MIX_W),
    .OUT_W (SAMPLE_W)
  ) u_mix_saturate (
    .acc    (acc_d),
    .sample (sat_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      acc_q      <= '0;
      mask_q     <= '0;
      ch_q       <= CH_LEFT;
      out_data_q <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef VOICE_TIMEOUT_EN
      wait_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
`ifdef VOICE_TIMEOUT_EN
      wait_q     <= wait_d;
`endif
      if (load_out) begin
        out_data_q <= sat_out;
      end
    end
  end

  assign bus.voice_req = (state_q == StReq) ? (NUM_VOICES'(1) << idx_q) : '0;
  assign bus.voice_ch  = ch_q;
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = ch_q;
  assign bus.overrun   = overrun_q;
`ifdef VOICE_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Directed bench for voice_mix_scheduler; the timeout case runs only with VOICE_TIMEOUT_EN.
module tb_voice_mix_scheduler;

  logic clk;
  logic rst;
  logic signed [15:0] vdata [4];
  logic [3:0] ack_en;
  logic [3:0] ack_force;
  int n_tests;
  int n_fail;
  int ovr_cnt;

  voice_mix_scheduler_if #(.NUM_VOICES(4), .SAMPLE_W(16)) vif ();

  voice_mix_scheduler #(
    .NUM_VOICES  (4),
    .SAMPLE_W    (16),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  assign vif.voice_data = {vdata[3], vdata[2], vdata[1], vdata[0]};
  assign vif.voice_ack  = (vif.voice_req & ack_en) | ack_force;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int d0, input int d1, input int d2, input int d3);
    vdata[0] = 16'(d0);
    vdata[1] = 16'(d1);
    vdata[2] = 16'(d2);
    vdata[3] = 16'(d3);
  endtask

  task automatic strobe(input logic ch, input logic [3:0] mask);
    vif.frame_strobe = 1'b1;
    vif.frame_ch     = ch;
    vif.mute_mask    = mask;
    tick();
    vif.frame_strobe = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!vif.out_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, int'(vif.out_valid), 1);
  endtask

  task automatic take_output(input string tag);
    vif.out_ready = 1'b1;
    tick();
    vif.out_ready = 1'b0;
    check(tag, int'(vif.out_valid), 0);
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    rst              = 1'b1;
    ack_en           = 4'b1111;
    ack_force        = 4'b0000;
    vif.frame_strobe = 1'b0;
    vif.frame_ch     = 1'b0;
    vif.mute_mask    = 4'b0000;
    vif.out_ready    = 1'b0;
    set_data(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    check("rst_req", int'(vif.voice_req), 0);
    check("rst_valid", int'(vif.out_valid), 0);
    check("rst_data", int'(vif.out_data), 0);
    check("rst_outch", int'(vif.out_ch), 0);
    check("rst_vch", int'(vif.voice_ch), 0);
    check("rst_ovr", int'(vif.overrun), 0);
    check("rst_tmo", int'(vif.timeout), 0);

    // Basic frame: 1000+2000-500+0, right channel, N+1 latency.
    set_data(1000, 2000, -500, 0);
    strobe(1'b1, 4'b0000);
    check("rr_req0", int'(vif.voice_req), 1);
    check("rr_vch", int'(vif.voice_ch), 1);
    tick();
    check("rr_req1", int'(vif.voice_req), 2);
    tick();
    check("rr_req2", int'(vif.voice_req), 4);
    tick();
    check("rr_req3", int'(vif.voice_req), 8);
    check("rr_notyet", int'(vif.out_valid), 0);
    tick();
    check("rr_valid_lat", int'(vif.out_valid), 1);
    check("rr_data", int'(vif.out_data), 2500);
    check("rr_ch", int'(vif.out_ch), 1);
    check("rr_req_off", int'(vif.voice_req), 0);
    take_output("rr_xfer");

    // Positive and negative saturation.
    set_data(20000, 20000, 20000, 20000);
    strobe(1'b0, 4'b0000);
    wait_valid("satp_wait", 20);
    check("satp_data", int'(vif.out_data), 32767);
    check("satp_ch", int'(vif.out_ch), 0);
    take_output("satp_xfer");
    set_data(-20000, -20000, -20000, -20000);
    strobe(1'b0, 4'b0000);
    wait_valid("satn_wait", 20);
    check("satn_data", int'(vif.out_data), -32768);
    take_output("satn_xfer");

    // All muted: straight to output with a cleared accumulator.
    strobe(1'b1, 4'b1111);
    check("mute_req", int'(vif.voice_req), 0);
    check("mute_valid", int'(vif.out_valid), 1);
    check("mute_data", int'(vif.out_data), 0);
    take_output("mute_xfer");

    // Voices 1 and 3 only; stray acks from unrequested voices 0 and 2 are ignored.
    set_data(100, 200, 300, 400);
    ack_force = 4'b0101;
    strobe(1'b0, 4'b0101);
    check("m5_req1", int'(vif.voice_req), 2);
    tick();
    check("m5_req3", int'(vif.voice_req), 8);
    tick();
    check("m5_valid", int'(vif.out_valid), 1);
    check("m5_data", int'(vif.out_data), 600);
    ack_force = 4'b0000;
    take_output("m5_xfer");

    // Backpressure with a strobe arriving mid-hold, then one in the transfer cycle.
    set_data(1, 2, 3, 4);
    strobe(1'b0, 4'b0000);
    wait_valid("ovr_wait", 20);
    ovr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      vif.frame_strobe = (i == 2);
      vif.frame_ch     = 1'b1;
      tick();
      if (vif.overrun) ovr_cnt++;
    end
    vif.frame_strobe = 1'b0;
    check("ovr_count", ovr_cnt, 1);
    check("ovr_hold_valid", int'(vif.out_valid), 1);
    check("ovr_hold_data", int'(vif.out_data), 10);
    check("ovr_hold_ch", int'(vif.out_ch), 0);
    vif.frame_strobe = 1'b1;
    vif.out_ready    = 1'b1;
    tick();
    vif.frame_strobe = 1'b0;
    vif.out_ready    = 1'b0;
    check("ovr_xfer_pulse", int'(vif.overrun), 1);
    check("ovr_xfer_valid", int'(vif.out_valid), 0);
    check("ovr_no_frame", int'(vif.voice_req), 0);
    tick();
    check("ovr_pulse_end", int'(vif.overrun), 0);
    check("ovr_still_idle", int'(vif.voice_req) | int'(vif.out_valid), 0);

    // Reset while voice 2 is stalled, strobe in the rst-release cycle.
    ack_en = 4'b1011;
    set_data(1000, 2000, -500, 0);
    strobe(1'b0, 4'b0000);
    for (int n = 0; n < 10 && vif.voice_req != 4'b0100; n++) tick();
    check("rstm_req2", int'(vif.voice_req), 4);
    rst = 1'b1;
    tick();
    check("rstm_req", int'(vif.voice_req), 0);
    check("rstm_valid", int'(vif.out_valid), 0);
    check("rstm_data", int'(vif.out_data), 0);
    ack_en = 4'b1111;
    rst = 1'b0;
    strobe(1'b1, 4'b0000);
    check("rstm_restart", int'(vif.voice_req), 1);
    wait_valid("rstm_wait", 20);
    check("rstm_sum", int'(vif.out_data), 2500);
    check("rstm_ch", int'(vif.out_ch), 1);
    take_output("rstm_xfer");

`ifdef VOICE_TIMEOUT_EN
    // Voice 1 silent: held 64 cycles, then skipped as zero.
    ack_en = 4'b1101;
    strobe(1'b0, 4'b0000);
    tick();
    check("tmo_req1", int'(vif.voice_req), 2);
    for (int i = 0; i < 63; i++) tick();
    check("tmo_last_wait", int'(vif.voice_req), 2);
    check("tmo_not_yet", int'(vif.timeout), 0);
    tick();
    check("tmo_pulse", int'(vif.timeout), 1);
    check("tmo_advanced", int'(vif.voice_req), 4);
    tick();
    check("tmo_pulse_end", int'(vif.timeout), 0);
    wait_valid("tmo_wait", 20);
    check("tmo_sum", int'(vif.out_data), 500);
    take_output("tmo_xfer");
    ack_en = 4'b1111;
`else
    check("tmo_tied", int'(vif.timeout), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
